// File: rtl/instr_fetch_if.sv
// rtl/instr_fetch_if.sv - ROM request/response and decode packet bundle for instr_fetch
// The master modport is the fetch stage; the slave side is the ROM plus decode.
`ifndef EXCEPTION_LEN
`define EXCEPTION_LEN 4
`define EXCEP_OK 4'd0
`define EXCEP_INSTR_MISALIGNED 4'd1
`define EXCEP_INVALID_MEM_READ 4'd5
`define MEM_WIDTH_WORD 2'd2
`endif

interface instr_fetch_if;
  logic [31:0]               romAddr_Out;
  logic [1:0]                romWidth_Out;
  logic                      romValid_Out;
  logic [31:0]               romData_In;
  logic                      romOK_In;
  logic [`EXCEPTION_LEN-1:0] romExcep_In;
  logic                      instrValid_Out;
  logic                      instrReady_In;
  logic [31:0]               instr_Out;
  logic [31:0]               pc_Out;
  logic [`EXCEPTION_LEN-1:0] exception_Out;

  modport master (
    output romAddr_Out, romWidth_Out, romValid_Out,
    input  romData_In, romOK_In, romExcep_In,
    output instrValid_Out, instr_Out, pc_Out, exception_Out,
    input  instrReady_In
  );

  modport slave (
    input  romAddr_Out, romWidth_Out, romValid_Out,
    output romData_In, romOK_In, romExcep_In,
    input  instrValid_Out, instr_Out, pc_Out, exception_Out,
    output instrReady_In
  );
endinterface

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - PC owner and ROM fetch stage; FETCH_MISALIGN_CHECK_EN traps misaligned PCs
// One ROM request per instruction; the packet is held for decode until accepted or flushed by redirect.
`ifndef EXCEPTION_LEN
`define EXCEPTION_LEN 4
`define EXCEP_OK 4'd0
`define EXCEP_INSTR_MISALIGNED 4'd1
`define EXCEP_INVALID_MEM_READ 4'd5
`define MEM_WIDTH_WORD 2'd2
`endif

module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          redirect_In,
  input  logic [31:0]   redirectPC_In,
  instr_fetch_if.master bus
);

  typedef enum logic [2:0] {ST_REQ, ST_WAIT, ST_HOLD, ST_DRAIN, ST_HALT} state_t;

`ifdef FETCH_MISALIGN_CHECK_EN
  localparam logic CHECK_ALIGN = 1'b1;
`else
  localparam logic CHECK_ALIGN = 1'b0;
`endif

  state_t                    r_state;
  logic [31:0]               r_pc;
  logic [31:0]               r_pc_out;
  logic [31:0]               r_instr;
  logic [`EXCEPTION_LEN-1:0] r_exc;
  logic                      r_rom_valid;
  logic                      r_instr_valid;

  logic [31:0] w_pc_next;
  logic        w_pc_misaligned;
  logic        w_next_misaligned;
  logic        w_redirect_misaligned;
  logic        w_issued_ok;
  logic        w_resp_pending;

  assign w_pc_next             = r_pc + 32'd4;
  assign w_pc_misaligned       = CHECK_ALIGN && (r_pc[1:0] != 2'b00);
  assign w_next_misaligned     = CHECK_ALIGN && (w_pc_next[1:0] != 2'b00);
  assign w_redirect_misaligned = CHECK_ALIGN && (redirectPC_In[1:0] != 2'b00);
  assign w_issued_ok           = (r_state == ST_REQ) && r_rom_valid && (bus.romExcep_In == `EXCEP_OK);
  // A response that lands in the redirect cycle itself is already gone, so no drain is needed.
  assign w_resp_pending        = w_issued_ok ||
                                 (((r_state == ST_WAIT) || (r_state == ST_DRAIN)) && !bus.romOK_In);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_REQ;
      r_pc          <= RESET_PC;
      r_pc_out      <= 32'd0;
      r_instr       <= 32'd0;
      r_exc         <= `EXCEP_OK;
      r_rom_valid   <= 1'b0;
      r_instr_valid <= 1'b0;
    end else if (redirect_In) begin
      r_pc          <= redirectPC_In;
      r_instr_valid <= 1'b0;
      if (w_resp_pending) begin
        r_state     <= ST_DRAIN;
        r_rom_valid <= 1'b0;
      end else begin
        r_state     <= ST_REQ;
        r_rom_valid <= !r_rom_valid && !w_redirect_misaligned;
      end
    end else begin
      case (r_state)
        ST_REQ: begin
          if (w_pc_misaligned) begin
            r_pc_out      <= r_pc;
            r_instr       <= 32'd0;
            r_exc         <= `EXCEP_INSTR_MISALIGNED;
            r_instr_valid <= 1'b1;
            r_state       <= ST_HOLD;
          end else if (!r_rom_valid) begin
            // Strobe is held low straight out of reset or after back-to-back redirects.
            r_rom_valid <= 1'b1;
          end else if (bus.romExcep_In != `EXCEP_OK) begin
            r_pc_out      <= r_pc;
            r_instr       <= 32'd0;
            r_exc         <= bus.romExcep_In;
            r_instr_valid <= 1'b1;
            r_rom_valid   <= 1'b0;
            r_state       <= ST_HOLD;
          end else begin
            r_rom_valid <= 1'b0;
            r_state     <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (bus.romOK_In) begin
            r_pc_out      <= r_pc;
            r_instr       <= bus.romData_In;
            r_exc         <= `EXCEP_OK;
            r_instr_valid <= 1'b1;
            r_state       <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (bus.instrReady_In) begin
            r_instr_valid <= 1'b0;
            if (r_exc == `EXCEP_OK) begin
              r_pc        <= w_pc_next;
              r_rom_valid <= !w_next_misaligned;
              r_state     <= ST_REQ;
            end else begin
              r_state <= ST_HALT;
            end
          end
        end
        ST_DRAIN: begin
          if (bus.romOK_In) begin
            r_rom_valid <= !w_pc_misaligned;
            r_state     <= ST_REQ;
          end
        end
        ST_HALT: begin
          r_rom_valid <= 1'b0;
        end
        default: begin
          r_rom_valid <= 1'b0;
          r_state     <= ST_REQ;
        end
      endcase
    end
  end

  assign bus.romAddr_Out    = r_pc;
  assign bus.romWidth_Out   = `MEM_WIDTH_WORD;
  assign bus.romValid_Out   = r_rom_valid;
  assign bus.instrValid_Out = r_instr_valid;
  assign bus.instr_Out      = r_instr;
  assign bus.pc_Out         = r_pc_out;
  assign bus.exception_Out  = r_exc;

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - self-checking bench for instr_fetch
// Cycle table for the basic flow, directed corner sequences, then random traffic against a packet-level model.
`ifndef EXCEPTION_LEN
`define EXCEPTION_LEN 4
`define EXCEP_OK 4'd0
`define EXCEP_INSTR_MISALIGNED 4'd1
`define EXCEP_INVALID_MEM_READ 4'd5
`define MEM_WIDTH_WORD 2'd2
`endif

module tb_instr_fetch;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect_in = 1'b0;
  logic [31:0] redirect_pc = 32'd0;

  instr_fetch_if bus();

  instr_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk           (clk),
    .rst           (rst),
    .redirect_In   (redirect_in),
    .redirectPC_In (redirect_pc),
    .bus           (bus)
  );

  always #5 clk = ~clk;

  // ROM: faults above 64KiB, except a top window that aliases so PC wrap can be exercised.
  int          rom_lat   = 1;
  int          resp_cnt  = 0;
  logic [31:0] resp_data = 32'd0;

  function automatic logic rom_fault(input logic [31:0] a);
    return (a >= 32'h0001_0000) && (a < 32'hFFFF_FFF0);
  endfunction

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return a ^ 32'h0000_0013;
  endfunction

  function automatic logic [3:0] exp_exc(input logic [31:0] a);
`ifdef FETCH_MISALIGN_CHECK_EN
    if (a[1:0] != 2'b00) return `EXCEP_INSTR_MISALIGNED;
`endif
    if (rom_fault(a)) return `EXCEP_INVALID_MEM_READ;
    return `EXCEP_OK;
  endfunction

  assign bus.romExcep_In = (bus.romValid_Out && rom_fault(bus.romAddr_Out)) ? `EXCEP_INVALID_MEM_READ : `EXCEP_OK;
  assign bus.romOK_In    = (resp_cnt == 1);
  assign bus.romData_In  = (resp_cnt == 1) ? resp_data : 32'hDEAD_BEEF;

  always @(posedge clk) begin
    if (bus.romValid_Out && !rom_fault(bus.romAddr_Out)) begin
      resp_cnt  <= rom_lat;
      resp_data <= rom_word(bus.romAddr_Out);
    end else if (resp_cnt > 0) begin
      resp_cnt <= resp_cnt - 1;
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_iv(input string name);
    logic found;
    found = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (bus.instrValid_Out) begin
        found = 1'b1;
        break;
      end
      cyc();
    end
    chk(name, found, 1);
  endtask

  task automatic wait_rv(input string name);
    logic found;
    found = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (bus.romValid_Out) begin
        found = 1'b1;
        break;
      end
      cyc();
    end
    chk(name, found, 1);
  endtask

  typedef struct {
    logic        ready;
    logic        redir;
    logic [31:0] tgt;
    logic        rv;
    logic [31:0] addr;
    logic        iv;
    logic [31:0] pc;
    logic [31:0] instr;
  } vec_t;

  function automatic vec_t v(input logic rd, input logic re, input logic [31:0] t, input logic rv,
                             input logic [31:0] a, input logic iv, input logic [31:0] p,
                             input logic [31:0] i);
    vec_t r;
    r.ready = rd; r.redir = re; r.tgt = t; r.rv = rv;
    r.addr = a; r.iv = iv; r.pc = p; r.instr = i;
    return r;
  endfunction

  vec_t        tbl[17];
  logic [31:0] exp_pc;
  logic [31:0] tmp;
  logic [3:0]  e_exc;
  logic        halted;
  logic        prev_rv;
  logic        saw_ok;
  logic        got;
  logic        r_ready;
  logic        r_redir;
  logic [31:0] r_tgt;
  int          stall;
  int          accepts;

  initial begin
    // inputs drive the cycle before the sample; outputs are the state after that edge
    tbl[0]  = v(1, 0, 0,        1, 32'h0,  0, 0, 0);
    tbl[1]  = v(1, 0, 0,        0, 0,      0, 0, 0);
    tbl[2]  = v(1, 0, 0,        0, 0,      1, 32'h0,  32'h13);
    tbl[3]  = v(1, 0, 0,        1, 32'h4,  0, 0, 0);
    tbl[4]  = v(1, 0, 0,        0, 0,      0, 0, 0);
    tbl[5]  = v(1, 0, 0,        0, 0,      1, 32'h4,  32'h17);
    for (int i = 6; i <= 10; i++) tbl[i] = v(0, 0, 0, 0, 0, 1, 32'h4, 32'h17);
    tbl[11] = v(1, 0, 0,        1, 32'h8,  0, 0, 0);
    tbl[12] = v(1, 0, 0,        0, 0,      0, 0, 0);
    tbl[13] = v(1, 0, 0,        0, 0,      1, 32'h8,  32'h1B);
    tbl[14] = v(1, 1, 32'h40,   1, 32'h40, 0, 0, 0);
    tbl[15] = v(1, 0, 0,        0, 0,      0, 0, 0);
    tbl[16] = v(0, 0, 0,        0, 0,      1, 32'h40, 32'h53);

    bus.instrReady_In = 1'b0;
    cyc();
    cyc();
    chk("reset_rom_valid", bus.romValid_Out, 0);
    chk("reset_instr_valid", bus.instrValid_Out, 0);
    chk("reset_pc_out", bus.pc_Out, 0);
    chk("reset_instr", bus.instr_Out, 0);
    chk("reset_exc", bus.exception_Out, `EXCEP_OK);
    chk("rom_width", bus.romWidth_Out, `MEM_WIDTH_WORD);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 17; i++) begin
      bus.instrReady_In = tbl[i].ready;
      redirect_in       = tbl[i].redir;
      redirect_pc       = tbl[i].tgt;
      cyc();
      chk($sformatf("vec%0d_rom_valid", i), bus.romValid_Out, tbl[i].rv);
      if (tbl[i].rv) chk($sformatf("vec%0d_rom_addr", i), bus.romAddr_Out, tbl[i].addr);
      chk($sformatf("vec%0d_instr_valid", i), bus.instrValid_Out, tbl[i].iv);
      if (tbl[i].iv) begin
        chk($sformatf("vec%0d_pc", i), bus.pc_Out, tbl[i].pc);
        chk($sformatf("vec%0d_instr", i), bus.instr_Out, tbl[i].instr);
        chk($sformatf("vec%0d_exc", i), bus.exception_Out, `EXCEP_OK);
      end
    end
    redirect_in = 1'b0;

    // redirect while the ROM is still stalled: the late response must be swallowed
    rom_lat = 3;
    bus.instrReady_In = 1'b1;
    cyc();
    chk("drain_req_valid", bus.romValid_Out, 1);
    chk("drain_req_addr", bus.romAddr_Out, 32'h44);
    bus.instrReady_In = 1'b0;
    cyc();
    chk("drain_wait_rv", bus.romValid_Out, 0);
    redirect_in = 1'b1;
    redirect_pc = 32'h100;
    cyc();
    redirect_in = 1'b0;
    saw_ok = 1'b0;
    got    = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (bus.romValid_Out) begin
        got = 1'b1;
        break;
      end
      chk("drain_no_packet", bus.instrValid_Out, 0);
      if (bus.romOK_In) saw_ok = 1'b1;
      cyc();
    end
    rom_lat = 1;
    chk("drain_req_seen", got, 1);
    chk("drain_resp_first", saw_ok, 1);
    chk("drain_new_addr", bus.romAddr_Out, 32'h100);
    wait_iv("drain_pkt_seen");
    chk("drain_pkt_pc", bus.pc_Out, 32'h100);
    chk("drain_pkt_instr", bus.instr_Out, 32'h113);

    // ROM fault: exception packet, then halt until redirected
    redirect_in = 1'b1;
    redirect_pc = 32'h0001_0000;
    cyc();
    redirect_in = 1'b0;
    chk("fault_req_valid", bus.romValid_Out, 1);
    chk("fault_req_addr", bus.romAddr_Out, 32'h0001_0000);
    cyc();
    chk("fault_pkt_valid", bus.instrValid_Out, 1);
    chk("fault_pkt_pc", bus.pc_Out, 32'h0001_0000);
    chk("fault_pkt_instr", bus.instr_Out, 0);
    chk("fault_pkt_exc", bus.exception_Out, `EXCEP_INVALID_MEM_READ);
    bus.instrReady_In = 1'b1;
    for (int k = 0; k < 6; k++) begin
      cyc();
      chk("halt_rom_valid", bus.romValid_Out, 0);
      chk("halt_instr_valid", bus.instrValid_Out, 0);
    end
    redirect_in = 1'b1;
    redirect_pc = 32'h0;
    cyc();
    redirect_in = 1'b0;
    chk("resume_req_valid", bus.romValid_Out, 1);
    chk("resume_req_addr", bus.romAddr_Out, 32'h0);
    bus.instrReady_In = 1'b0;
    wait_iv("resume_pkt_seen");
    chk("resume_pkt_pc", bus.pc_Out, 32'h0);
    chk("resume_pkt_instr", bus.instr_Out, 32'h13);

    redirect_in = 1'b1;
    redirect_pc = 32'h2;
    cyc();
    redirect_in = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
    chk("misalign_no_req", bus.romValid_Out, 0);
    cyc();
    chk("misalign_no_req2", bus.romValid_Out, 0);
    chk("misalign_pkt_valid", bus.instrValid_Out, 1);
    chk("misalign_pkt_pc", bus.pc_Out, 32'h2);
    chk("misalign_pkt_instr", bus.instr_Out, 0);
    chk("misalign_pkt_exc", bus.exception_Out, `EXCEP_INSTR_MISALIGNED);
`else
    chk("unaligned_req_valid", bus.romValid_Out, 1);
    chk("unaligned_req_addr", bus.romAddr_Out, 32'h2);
    wait_iv("unaligned_pkt_seen");
    chk("unaligned_pkt_pc", bus.pc_Out, 32'h2);
    chk("unaligned_pkt_instr", bus.instr_Out, 32'h11);
    chk("unaligned_pkt_exc", bus.exception_Out, `EXCEP_OK);
`endif

    redirect_in = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    cyc();
    redirect_in = 1'b0;
    wait_rv("wrap_req_seen");
    chk("wrap_req_addr", bus.romAddr_Out, 32'hFFFF_FFFC);
    wait_iv("wrap_pkt_seen");
    chk("wrap_pkt_pc", bus.pc_Out, 32'hFFFF_FFFC);
    chk("wrap_pkt_instr", bus.instr_Out, 32'hFFFF_FFEF);
    bus.instrReady_In = 1'b1;
    cyc();
    chk("wrap_next_valid", bus.romValid_Out, 1);
    chk("wrap_next_addr", bus.romAddr_Out, 32'h0);

    // random traffic against a model that only tracks the expected PC and halt status
    prev_rv = bus.romValid_Out;
    redirect_in = 1'b1;
    redirect_pc = 32'h0;
    bus.instrReady_In = 1'b0;
    cyc();
    redirect_in = 1'b0;
    exp_pc  = 32'h0;
    halted  = 1'b0;
    stall   = 0;
    accepts = 0;
    for (int n = 0; n < 3000; n++) begin
      e_exc = exp_exc(exp_pc);
      if (bus.romValid_Out) begin
        chk("rnd_rv_gap", prev_rv, 0);
        chk("rnd_rv_halted", halted, 0);
        chk("rnd_rv_addr", bus.romAddr_Out, exp_pc);
        chk("rnd_rv_misaligned", e_exc == `EXCEP_INSTR_MISALIGNED, 0);
        chk("rnd_rv_outstanding", resp_cnt > 1, 0);
      end
      if (halted) chk("rnd_halt_iv", bus.instrValid_Out, 0);
      if (bus.instrValid_Out) begin
        chk("rnd_pc", bus.pc_Out, exp_pc);
        chk("rnd_exc", bus.exception_Out, e_exc);
        chk("rnd_instr", bus.instr_Out, (e_exc == `EXCEP_OK) ? rom_word(exp_pc) : 32'h0);
      end
      if (!halted && !bus.romValid_Out && !bus.instrValid_Out) stall++;
      else stall = 0;
      chk("rnd_progress", stall > 12, 0);

      tmp = $urandom;
      case ($urandom_range(0, 5))
        0, 1:    r_tgt = tmp & 32'h0000_FFFC;
        2:       r_tgt = 32'h0000_FFF0 + (tmp & 32'hC);
        3:       r_tgt = 32'h0001_0000 + (tmp & 32'hFFC);
        4:       r_tgt = tmp & 32'h0000_0FFF;
        default: r_tgt = 32'hFFFF_FFF0 + (tmp & 32'hC);
      endcase
      r_ready = ($urandom_range(0, 3) != 0);
      r_redir = ($urandom_range(0, 19) == 0);
      rom_lat = $urandom_range(1, 3);

      if (r_redir) begin
        exp_pc = r_tgt;
        halted = 1'b0;
      end else if (bus.instrValid_Out && r_ready) begin
        accepts++;
        if (e_exc == `EXCEP_OK) exp_pc = exp_pc + 32'd4;
        else halted = 1'b1;
      end
      prev_rv = bus.romValid_Out;
      bus.instrReady_In = r_ready;
      redirect_in = r_redir;
      redirect_pc = r_tgt;
      cyc();
    end
    redirect_in = 1'b0;
    chk("rnd_accepts_seen", accepts > 50, 1);

    // asynchronous reset while a packet is presented
    rom_lat = 1;
    bus.instrReady_In = 1'b0;
    redirect_in = 1'b1;
    redirect_pc = 32'h20;
    cyc();
    redirect_in = 1'b0;
    wait_iv("areset_pkt_seen");
    #3;
    rst = 1'b1;
    #1;
    chk("areset_instr_valid", bus.instrValid_Out, 0);
    chk("areset_rom_valid", bus.romValid_Out, 0);
    chk("areset_pc_out", bus.pc_Out, 0);
    chk("areset_instr", bus.instr_Out, 0);
    chk("areset_exc", bus.exception_Out, `EXCEP_OK);
    chk("areset_rom_addr", bus.romAddr_Out, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
